spi_slave_frontend: RTL

//   SPI mode-0 slave that decodes serial frames from the host into parallel register

---
 rtl/spi_slave_frontend_if.sv | 26 ++
 rtl/spi_slave_frontend.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_frontend_if.sv
// SPI pin and register-file bus bundle for spi_slave_frontend.
// The slave modport is the frontend's own view; master is the view of
// whatever drives the SPI pins and serves register reads.
interface spi_slave_frontend_if;
  logic        i_sclk;
  logic        i_cs_n;
  logic        i_mosi;
  logic        o_miso;
  logic        o_miso_oe;
  logic [15:0] o_addr;
  logic [15:0] o_wdata;
  logic        o_wr;
  logic [15:0] i_rdata;
  logic        o_busy;
  logic        o_frame_err;

  modport slave (
    input  i_sclk, i_cs_n, i_mosi, i_rdata,
    output o_miso, o_miso_oe, o_addr, o_wdata, o_wr, o_busy, o_frame_err
  );

  modport master (
    output i_sclk, i_cs_n, i_mosi, i_rdata,
    input  o_miso, o_miso_oe, o_addr, o_wdata, o_wr, o_busy, o_frame_err
  );
endinterface

// File: rtl/spi_slave_frontend.sv
// SPI mode-0 slave that turns 32-bit host frames into register-file
// transactions. Frame layout (MSB first): bit31 = write flag, bits30:16 =
// address, bits15:0 = write data. Read data is returned on MISO during
// the second half of a read frame. SPI pins are oversampled by clk.
module spi_slave_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 2
) (
  input logic                 clk,
  input logic                 rst,
  spi_slave_frontend_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RD_WAIT,
    S_DATA,
    S_WR,
    S_DONE
  } state_t;

  // Synchroniser reset values, ordered {cs_n, sclk, mosi}: CS_N idles high.
  localparam logic [2:0] SYNC_RST = 3'b100;

  logic [2:0] pin_raw;
  logic [2:0] pin_sync;

  assign pin_raw = {bus.i_cs_n, bus.i_sclk, bus.i_mosi};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_q;

      // Bring one asynchronous SPI pin into the clk domain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chain_q <= {SYNC_STAGES{SYNC_RST[gi]}};
        end else begin
          chain_q <= {chain_q[SYNC_STAGES-2:0], pin_raw[gi]};
        end
      end

      assign pin_sync[gi] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic sclk_prev_q;
  logic sclk_rise;
  logic sclk_fall;

  assign cs_s   = pin_sync[2];
  assign sclk_s = pin_sync[1];
  assign mosi_s = pin_sync[0];

  // Remember the previous synchronised SCLK level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  state_t      state_q;
  logic [5:0]  bit_cnt_q;
  logic        rw_q;
  logic [15:0] cmd_sr_q;
  logic [15:0] data_sr_q;
  logic [15:0] hold_q;
  logic [15:0] tx_sr_q;
  logic [7:0]  rd_cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic        err_q;

  logic [15:0] cmd_sr_d;
  logic [15:0] data_sr_d;
  logic [5:0]  bit_cnt_d;

  assign cmd_sr_d  = {cmd_sr_q[14:0], mosi_s};
  assign data_sr_d = {data_sr_q[14:0], mosi_s};
  assign bit_cnt_d = bit_cnt_q + 6'd1;

  // Frame FSM: command decode, read-data fetch, data phase and write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 6'd0;
      rw_q      <= 1'b0;
      cmd_sr_q  <= 16'h0000;
      data_sr_q <= 16'h0000;
      hold_q    <= 16'h0000;
      tx_sr_q   <= 16'h0000;
      rd_cnt_q  <= 8'd0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      if (cs_s) begin
        // Releasing CS_N always ends the frame; a partial frame is an error.
        // Checking CS_N first means it beats a coincident 32nd SCLK rise.
        if (state_q != S_IDLE && bit_cnt_q != 6'd0 && bit_cnt_q < 6'd32) begin
          err_q <= 1'b1;
        end
        state_q   <= S_IDLE;
        bit_cnt_q <= 6'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q   <= S_CMD;
            bit_cnt_q <= 6'd0;
          end
          S_CMD: begin
            if (sclk_rise) begin
              cmd_sr_q  <= cmd_sr_d;
              bit_cnt_q <= bit_cnt_d;
              if (bit_cnt_q == 6'd15) begin
                addr_q   <= {1'b0, cmd_sr_d[14:0]};
                rw_q     <= cmd_sr_d[15];
                rd_cnt_q <= 8'd0;
                state_q  <= cmd_sr_d[15] ? S_DATA : S_RD_WAIT;
              end
            end
          end
          S_RD_WAIT: begin
            // Give the register file RD_LAT cycles to present the new address.
            rd_cnt_q <= rd_cnt_q + 8'd1;
            if (rd_cnt_q == 8'(RD_LAT - 1)) begin
              hold_q  <= bus.i_rdata;
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            if (sclk_rise) begin
              data_sr_q <= data_sr_d;
              bit_cnt_q <= bit_cnt_d;
              if (bit_cnt_q == 6'd31) begin
                state_q <= rw_q ? S_WR : S_DONE;
              end
            end
            // Falling edge after bit 16 loads the read data; later ones shift it.
            if (sclk_fall && !rw_q) begin
              tx_sr_q <= (bit_cnt_q == 6'd16) ? hold_q : {tx_sr_q[14:0], 1'b0};
            end
          end
          S_WR: begin
            wdata_q <= data_sr_q;
            wr_q    <= 1'b1;
            state_q <= S_DONE;
          end
          S_DONE: begin
            // Extra SCLK edges beyond 32 are ignored until CS_N rises.
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_miso      = (state_q == S_DATA && !rw_q) ? tx_sr_q[15] : 1'b0;
  assign bus.o_miso_oe   = ~cs_s;
  assign bus.o_addr      = addr_q;
  assign bus.o_wdata     = wdata_q;
  assign bus.o_wr        = wr_q;
  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_frame_err = err_q;

endmodule
